// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver front end.
// Captures 11-bit frames (start, D0..D7 LSB-first, even parity, stop) into a
// left-shifting register and publishes the whole frame, unfiltered, on
// completion. Parity and framing are judged downstream.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [10:0] buffer,
  output logic        frame_valid,
  output logic        busy
);

  // Counter only ever has to reach CLKS_PER_BIT-1 before it is cleared.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [10:0]     shreg_q, shreg_d;
  logic [10:0]     buffer_q, buffer_d;
  logic            fv_q, fv_d;
  logic            rx_meta_q;
  logic            rx_s_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counter, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 4'd0;
      shreg_q   <= 11'd0;
      buffer_q  <= 11'd0;
      fv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      buffer_q  <= buffer_d;
      fv_q      <= fv_d;
    end
  end

  // Next-state logic: half-bit wait to centre on the start bit, then one
  // sample per full bit period for D0..D7, parity and stop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    buffer_d  = buffer_q;
    fv_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            shreg_d   = {shreg_q[9:0], 1'b0};
            bit_idx_d = 4'd0;
            state_d   = DATA;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shreg_d = {shreg_q[9:0], rx_s_q};
          if (bit_idx_q == 4'd8) begin
            bit_idx_d = 4'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d    = '0;
          shreg_d  = {shreg_q[9:0], rx_s_q};
          buffer_d = {shreg_q[9:0], rx_s_q};
          fv_d     = 1'b1;
          // A low stop bit may be a break; wait for the line to recover.
          state_d  = rx_s_q ? IDLE : WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign buffer      = buffer_q;
  assign frame_valid = fv_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at 16 clocks per bit.
module tb_uart_rx_sampler;

  localparam int CPB = 16;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [10:0] buffer;
  logic        frame_valid;
  logic        busy;

  uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .buffer      (buffer),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          fv_count = 0;
  int          last_cyc = 0;
  int          prev_cyc = 0;
  logic [10:0] last_buf = 11'd0;
  logic        fv_prev = 1'b0;
  logic        fv_double = 1'b0;
  int          fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-valid monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count = fv_count + 1;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      last_buf = buffer;
      if (fv_prev) fv_double = 1'b1;
    end
    fv_prev = frame_valid;
  end

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic [10:0] exp_buf;
  } vec_t;

  vec_t vecs[7];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests = tests + 1;
    if (act < lo || act > hi) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drive the first nbits bits of a frame; caller is #1 after a clock edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      tick(CPB);
    end
  endtask

  initial begin
    int          n0;
    logic [10:0] hold;

    vecs[0] = '{"a5",      8'hA5, 1'b0, 1'b1, 11'b0_10100101_0_1};
    vecs[1] = '{"01",      8'h01, 1'b1, 1'b1, 11'b0_10000000_1_1};
    vecs[2] = '{"80",      8'h80, 1'b1, 1'b1, 11'b0_00000001_1_1};
    vecs[3] = '{"0f",      8'h0F, 1'b0, 1'b1, 11'b0_11110000_0_1};
    vecs[4] = '{"5a_bad",  8'h5A, 1'b1, 1'b1, 11'b0_01011010_1_1};
    vecs[5] = '{"5a_good", 8'h5A, 1'b0, 1'b1, 11'b0_01011010_0_1};
    vecs[6] = '{"3c",      8'h3C, 1'b0, 1'b1, 11'b0_00111100_0_1};

    rst = 1'b1;
    rx  = 1'b1;
    tick(4);
    check("rst_buffer", 32'(buffer), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(3);

    // Table of clean and bad-parity frames.
    for (int v = 0; v < 7; v++) begin
      n0 = fv_count;
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 11);
      check({vecs[v].name, "_pulses"}, 32'(fv_count - n0), 32'd1);
      check({vecs[v].name, "_fvbuf"}, 32'(last_buf), 32'(vecs[v].exp_buf));
      check_range({vecs[v].name, "_latency"}, last_cyc - fall_cyc, 169, 171);
      check({vecs[v].name, "_busy"}, 32'(busy), 32'h0);
      check({vecs[v].name, "_hold"}, 32'(buffer), 32'(vecs[v].exp_buf));
      tick(2);
    end

    // Start glitch: 5 cycles low then high.
    hold = buffer;
    n0   = fv_count;
    rx = 1'b0;
    tick(4);
    check("glitch_busy_start", 32'(busy), 32'h1);
    tick(1);
    rx = 1'b1;
    tick(40);
    check("glitch_pulses", 32'(fv_count - n0), 32'd0);
    check("glitch_buffer", 32'(buffer), 32'(hold));
    check("glitch_idle", 32'(busy), 32'h0);

    // Stop bit low: frame still published, then hold in WAIT_IDLE.
    n0 = fv_count;
    send_frame(8'h01, 1'b1, 1'b0, 11);
    check("brk_pulses", 32'(fv_count - n0), 32'd1);
    check("brk_buf", 32'(last_buf), 32'(11'b0_10000000_1_0));
    check("brk_stop_bit", 32'(buffer[0]), 32'h0);
    check("brk_busy", 32'(busy), 32'h1);
    tick(30);
    check("brk_busy_hold", 32'(busy), 32'h1);
    check("brk_no_retrigger", 32'(fv_count - n0), 32'd1);
    rx = 1'b1;
    tick(5);
    check("brk_release", 32'(busy), 32'h0);
    tick(2);

    // Reset in the middle of D3, then a clean 0x3C frame.
    n0 = fv_count;
    send_frame(8'hC3, 1'b0, 1'b1, 4);
    rx = 1'b0;
    tick(8);
    check("mid_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_buffer", 32'(buffer), 32'h0);
    check("mid_rst_fv", 32'(frame_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    tick(3);
    rx  = 1'b1;
    rst = 1'b0;
    tick(200);
    check("mid_no_pulse", 32'(fv_count - n0), 32'd0);
    check("mid_buffer_cleared", 32'(buffer), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b1, 11);
    check("mid_3c_pulses", 32'(fv_count - n0), 32'd1);
    check("mid_3c_buf", 32'(buffer), 32'(11'b0_00111100_0_1));
    tick(2);

    // Back-to-back 0xFF then 0x00 with no idle gap.
    n0 = fv_count;
    send_frame(8'hFF, 1'b0, 1'b1, 11);
    check("b2b_ff_buf", 32'(last_buf), 32'(11'b0_11111111_0_1));
    send_frame(8'h00, 1'b0, 1'b1, 11);
    check("b2b_pulses", 32'(fv_count - n0), 32'd2);
    check("b2b_00_buf", 32'(buffer), 32'(11'b0_00000000_0_1));
    check_range("b2b_spacing", last_cyc - prev_cyc, 11 * CPB - 1, 11 * CPB + 1);
    check("b2b_busy", 32'(busy), 32'h0);

    check("fv_never_double", 32'(fv_double), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
